// File: rtl/result_drain_m_axis.sv
// AXI-Stream master that drains the result BRAM (addresses 0..word_count-1) to the S2MM DMA path.
// A 2-entry skid FIFO plus the single in-flight BRAM read absorb TREADY backpressure.
module result_drain_m_axis #(
    parameter int BRAM_DEPTH           = 10,
    parameter int C_M_AXIS_TDATA_WIDTH = 32
) (
    input  logic                                M_AXIS_ACLK,
    input  logic                                M_AXIS_ARESET,
    input  logic                                start,
    input  logic [BRAM_DEPTH:0]                 word_count,
    output logic                                busy,
    output logic                                done,
    output logic [BRAM_DEPTH-1:0]               res_addr,
    output logic                                res_en,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     res_dout,
    output logic                                M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
    output logic                                M_AXIS_TLAST,
    input  logic                                M_AXIS_TREADY
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                          state_reg;
    state_t                          state_next;
    logic [BRAM_DEPTH:0]             count_reg;
    logic [BRAM_DEPTH:0]             rd_ptr_reg;
    logic                            inflight_reg;
    logic                            inflight_last_reg;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] fifo_data_reg [2];
    logic                            fifo_last_reg [2];
    logic                            fifo_wr_ptr_reg;
    logic                            fifo_rd_ptr_reg;
    logic [1:0]                      fifo_occ_reg;

    logic                            start_accept;
    logic                            pop;
    logic                            fifo_push;
    logic                            fifo_pop;
    logic                            issue_last;
    logic [2:0]                      queue_depth;

    // The in-flight read is the tail of the visible queue: when the FIFO is
    // empty the BRAM output is presented directly, giving TVALID two cycles after start.
    assign M_AXIS_TVALID = (fifo_occ_reg != 2'd0) || inflight_reg;
    assign M_AXIS_TDATA  = (fifo_occ_reg != 2'd0) ? fifo_data_reg[fifo_rd_ptr_reg] :
                           inflight_reg           ? res_dout : '0;
    assign M_AXIS_TLAST  = (fifo_occ_reg != 2'd0) ? fifo_last_reg[fifo_rd_ptr_reg] :
                           inflight_reg           ? inflight_last_reg : 1'b0;
    assign M_AXIS_TSTRB  = '1;

    assign pop          = M_AXIS_TVALID && M_AXIS_TREADY;
    assign start_accept = (state_reg == ST_IDLE) && start;
    assign fifo_push    = inflight_reg && !((fifo_occ_reg == 2'd0) && pop);
    assign fifo_pop     = pop && (fifo_occ_reg != 2'd0);
    assign queue_depth  = {1'b0, fifo_occ_reg} + {2'b0, inflight_reg} - {2'b0, pop};
    assign issue_last   = (rd_ptr_reg == count_reg - {{BRAM_DEPTH{1'b0}}, 1'b1});
    assign res_addr     = rd_ptr_reg[BRAM_DEPTH-1:0];

    always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
        if (M_AXIS_ARESET) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = (word_count == '0) ? ST_DONE : ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (pop && M_AXIS_TLAST) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Issue only while the queue (FIFO + in-flight, net of this cycle's pop) has room.
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        res_en = 1'b0;
        case (state_reg)
            ST_STREAM: begin
                busy   = 1'b1;
                res_en = (rd_ptr_reg < count_reg) && (queue_depth < 3'd2);
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
        if (M_AXIS_ARESET) begin
            count_reg         <= '0;
            rd_ptr_reg        <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
            fifo_wr_ptr_reg   <= 1'b0;
            fifo_rd_ptr_reg   <= 1'b0;
            fifo_occ_reg      <= 2'd0;
        end else begin
            if (start_accept) begin
                count_reg  <= word_count;
                rd_ptr_reg <= '0;
            end else if (res_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            inflight_reg      <= res_en;
            inflight_last_reg <= res_en && issue_last;
            if (fifo_push) begin
                fifo_wr_ptr_reg <= ~fifo_wr_ptr_reg;
            end
            if (fifo_pop) begin
                fifo_rd_ptr_reg <= ~fifo_rd_ptr_reg;
            end
            fifo_occ_reg <= fifo_occ_reg + {1'b0, fifo_push} - {1'b0, fifo_pop};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo_entry
            always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
                if (M_AXIS_ARESET) begin
                    fifo_data_reg[gi] <= '0;
                    fifo_last_reg[gi] <= 1'b0;
                end else if (fifo_push && (fifo_wr_ptr_reg == 1'(gi))) begin
                    fifo_data_reg[gi] <= res_dout;
                    fifo_last_reg[gi] <= inflight_last_reg;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_result_drain_m_axis.sv
// Bench for result_drain_m_axis: BRAM model, expected-beat model checked every cycle,
// plus directed drains with hand-computed latencies.
module tb_result_drain_m_axis;

    localparam int BD = 10;
    localparam int W  = 32;

    logic          clk;
    logic          rst;
    logic          start;
    logic [BD:0]   word_count;
    logic          busy;
    logic          done;
    logic [BD-1:0] res_addr;
    logic          res_en;
    logic [W-1:0]  res_dout;
    logic          tvalid;
    logic [W-1:0]  tdata;
    logic [W/8-1:0] tstrb;
    logic          tlast;
    logic          tready;

    result_drain_m_axis #(.BRAM_DEPTH(BD), .C_M_AXIS_TDATA_WIDTH(W)) dut (
        .M_AXIS_ACLK  (clk),
        .M_AXIS_ARESET(rst),
        .start        (start),
        .word_count   (word_count),
        .busy         (busy),
        .done         (done),
        .res_addr     (res_addr),
        .res_en       (res_en),
        .res_dout     (res_dout),
        .M_AXIS_TVALID(tvalid),
        .M_AXIS_TDATA (tdata),
        .M_AXIS_TSTRB (tstrb),
        .M_AXIS_TLAST (tlast),
        .M_AXIS_TREADY(tready)
    );

    int vectors = 0;
    int miscompares = 0;

    // Shared between main (writes) and monitor (reads)
    int start_cyc = -100;
    int exp_n = 0;
    bit active = 0;
    int cyc = 0;

    // Written by monitor only
    int beat_idx = 0;
    int addr_idx = 0;
    int en_cnt = 0;
    int en_at_11 = -1;
    int done_cnt = 0;
    int done_rel = -1;
    int first_valid_rel = -1;
    int last_hs_rel = -1;
    int busy_at_1 = -1;
    bit prev_stall = 0;
    logic [W-1:0] prev_data = '0;
    logic prev_last = 1'b0;

    logic [W-1:0] mem [0:(1<<BD)-1];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        for (int i = 0; i < (1 << BD); i++) mem[i] = 32'h100 + i;
        res_dout = '0;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (res_en) res_dout <= mem[res_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected stream: beat k carries BRAM[k] = 0x100+k, TLAST only on k == n-1.
    always @(negedge clk) begin
        int rel;
        if (rst) begin
            prev_stall = 0;
        end else if (active) begin
            rel = cyc - start_cyc;
            if (start && cyc == start_cyc) begin
                beat_idx = 0; addr_idx = 0; en_cnt = 0; en_at_11 = -1;
                done_cnt = 0; done_rel = -1; first_valid_rel = -1;
                last_hs_rel = -1; busy_at_1 = -1; prev_stall = 0;
            end
            if (rel == 1) busy_at_1 = int'(busy);
            if (res_en) begin
                chk("read_in_range", addr_idx < exp_n, 1);
                chk("res_addr", res_addr, addr_idx[BD-1:0]);
                addr_idx++;
                en_cnt++;
            end
            if (rel == 11) en_at_11 = en_cnt;
            if (prev_stall) begin
                chk("stall_valid", tvalid, 1);
                chk("stall_data", tdata, prev_data);
                chk("stall_last", tlast, prev_last);
            end
            if (tvalid && first_valid_rel < 0) first_valid_rel = rel;
            if (tvalid && tready) begin
                chk("beat_in_range", beat_idx < exp_n, 1);
                chk("beat_data", tdata, 32'h100 + beat_idx);
                chk("beat_last", tlast, beat_idx == exp_n - 1);
                beat_idx++;
                last_hs_rel = rel;
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
            if (done) begin
                done_cnt++;
                done_rel = rel;
            end
        end
    end

    function automatic logic ready_for(input int mode, input int r);
        case (mode)
            0:       return 1'b1;
            1:       return (r % 2) == 0;
            default: return r > 11;
        endcase
    endfunction

    // mode: 0 ready, 1 toggling, 2 stalled through rel 11; poke: extra start at rel 1;
    // abort_beats: assert reset once that many beats have handshaken.
    task automatic drain(input int n, input int mode, input bit poke, input int abort_beats);
        int r;
        exp_n = n;
        active = 1;
        @(posedge clk); #1;
        start_cyc = cyc;
        start = 1'b1;
        word_count = (BD+1)'(n);
        tready = ready_for(mode, 0);
        r = 1;
        while (r < 3 * n + 40) begin
            @(posedge clk); #1;
            start = poke && (r == 1);
            word_count = (poke && r == 1) ? (BD+1)'(5) : (BD+1)'(n);
            tready = ready_for(mode, r);
            if (done_rel >= 0) break;
            if (abort_beats > 0 && beat_idx >= abort_beats) break;
            r++;
        end
        if (abort_beats > 0) begin
            chk("abort_reached", beat_idx >= abort_beats, 1);
            #1 rst = 1'b1;
            #1;
            chk("abort_tvalid", tvalid, 0);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            chk("abort_tlast", tlast, 0);
            @(posedge clk); @(posedge clk); #1 rst = 1'b0;
            $display("drain n=%0d aborted after %0d beats", n, beat_idx);
            return;
        end
        chk("drain_finished", done_rel >= 0, 1);
        start = 1'b0;
        tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("beats_total", beat_idx, n);
        chk("reads_total", addr_idx, n);
        chk("done_once", done_cnt, 1);
        chk("idle_after", busy, 0);
        if (n > 0) chk("done_after_last", done_rel, last_hs_rel + 1);
        $display("drain n=%0d mode=%0d beats=%0d first_valid=%0d done_at=%0d",
                 n, mode, beat_idx, first_valid_rel, done_rel);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        word_count = '0;
        tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_res_en", res_en, 0);
        chk("rst_res_addr", res_addr, 0);
        chk("tstrb", tstrb, 4'hF);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        drain(4, 0, 0, 0);
        chk("t1_first_valid", first_valid_rel, 2);
        chk("t1_done_cycle", done_rel, 6);

        drain(8, 1, 0, 0);

        drain(16, 2, 0, 0);
        chk("t3_reads_while_stalled", en_at_11, 2);

        drain(0, 0, 0, 0);
        chk("t4_done_cycle", done_rel, 1);
        chk("t4_busy_c1", busy_at_1, 1);
        chk("t4_no_valid", first_valid_rel, -1);
        chk("t4_no_reads", en_cnt, 0);

        drain(1024, 0, 0, 0);
        chk("t5_done_cycle", done_rel, 1026);

        drain(8, 0, 0, 3);
        drain(2, 0, 1, 0);
        chk("t6_first_valid", first_valid_rel, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
